// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a DIGITS-wide 7-segment display.
// Captures the packed nibbles and decimal points once per frame, decodes them, and
// scans one digit per slot. Each slot opens with an all-off anti-ghosting interval.
module seven_seg_scanner #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          COMMON_ANODE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] d,
    input  logic [DIGITS-1:0]   dp,
    input  logic                lz_blank,
    output logic [6:0]          seg,
    output logic                seg_dp,
    output logic [DIGITS-1:0]   dig,
    output logic                frame
);

    localparam int unsigned PRES_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned D_W    = 4 * DIGITS;

    // Inactive levels: all-zero for common cathode, all-one for common anode.
    localparam logic [6:0]        SEG_OFF = {7{COMMON_ANODE}};
    localparam logic              DP_OFF  = COMMON_ANODE;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{COMMON_ANODE}};

    // Parameter legality checks at elaboration time.
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_scanner: DIGITS must be in 1..8");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("seven_seg_scanner: BLANK_CYCLES must be >= 1");
    end
    if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_div
        $error("seven_seg_scanner: BLANK_CYCLES must be < REFRESH_DIV");
    end

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // Scan state and frame snapshot.
    logic [PRES_W-1:0] pres_q;
    logic [IDX_W-1:0]  idx_q;
    logic [D_W-1:0]    snap_d_q;
    logic [DIGITS-1:0] snap_dp_q;

    // Combinational next-state and output candidates.
    logic [PRES_W-1:0] pres_nxt_c;
    logic [IDX_W-1:0]  idx_nxt_c;
    logic              frame_start_c;
    phase_t            phase_c;
    logic [DIGITS-1:0] lz_mask_c;
    logic              zero_run_c;
    logic [3:0]        cur_nib_c;
    logic              cur_dp_c;
    logic              cur_blank_c;
    logic [6:0]        seg_c;
    logic              seg_dp_c;
    logic [DIGITS-1:0] dig_c;

    // Hex to gfedcba segment pattern, active-high.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0:    r = 7'h3F;
            4'h1:    r = 7'h06;
            4'h2:    r = 7'h5B;
            4'h3:    r = 7'h4F;
            4'h4:    r = 7'h66;
            4'h5:    r = 7'h6D;
            4'h6:    r = 7'h7D;
            4'h7:    r = 7'h07;
            4'h8:    r = 7'h7F;
            4'h9:    r = 7'h6F;
            4'hA:    r = 7'h77;
            4'hB:    r = 7'h7C;
            4'hC:    r = 7'h39;
            4'hD:    r = 7'h5E;
            4'hE:    r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    // Prescaler and digit-index advance; idx steps when the slot counter wraps.
    always_comb begin
        pres_nxt_c = pres_q + PRES_W'(1);
        idx_nxt_c  = idx_q;
        if (pres_q == PRES_W'(REFRESH_DIV - 1)) begin
            pres_nxt_c = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_nxt_c = '0;
            end else begin
                idx_nxt_c = idx_q + IDX_W'(1);
            end
        end
    end

    // First cycle of slot 0 is the only point where new data is taken.
    always_comb begin
        frame_start_c = (idx_q == '0) && (pres_q == '0);
    end

    // Leading-zero mask: digit k (k >= 1) blanks when it and every higher digit is zero.
    always_comb begin
        zero_run_c = lz_blank;
        lz_mask_c  = '0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_run_c   = zero_run_c & (snap_d_q[4*k +: 4] == 4'h0);
            lz_mask_c[k] = zero_run_c;
        end
    end

    // Select the snapshot nibble, decimal point and blank flag of the current digit.
    always_comb begin
        cur_nib_c   = 4'h0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib_c   = snap_d_q[4*k +: 4];
                cur_dp_c    = snap_dp_q[k];
                cur_blank_c = lz_mask_c[k];
            end
        end
    end

    // Phase and active-high output values for the current state.
    always_comb begin
        seg_c    = 7'h00;
        seg_dp_c = 1'b0;
        dig_c    = '0;
        phase_c  = (pres_q < PRES_W'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
        if (phase_c == PH_DRIVE) begin
            dig_c    = DIGITS'(1) << idx_q;
            seg_dp_c = cur_dp_c;
            if (!cur_blank_c) begin
                seg_c = hex_decode(cur_nib_c);
            end
        end
    end

    // Scan counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_q <= '0;
            idx_q  <= '0;
        end else begin
            pres_q <= pres_nxt_c;
            idx_q  <= idx_nxt_c;
        end
    end

    // Frame snapshot of digit data and decimal points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_d_q  <= '0;
            snap_dp_q <= '0;
        end else if (frame_start_c) begin
            snap_d_q  <= d;
            snap_dp_q <= dp;
        end
    end

    // Registered outputs with polarity applied; reset forces the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame  <= 1'b0;
            seg    <= SEG_OFF;
            seg_dp <= DP_OFF;
            dig    <= DIG_OFF;
        end else begin
            frame  <= frame_start_c;
            seg    <= seg_c ^ SEG_OFF;
            seg_dp <= seg_dp_c ^ DP_OFF;
            dig    <= dig_c ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner (4 digits, 8-cycle slots, 2 blank).
module tb_seven_seg_scanner;

    localparam int NV   = 21;
    localparam int FLEN = 32;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] d;
    logic [3:0]  dp;
    logic        lz;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  dig;
    logic        frame;

    logic [15:0] d_ca;
    logic [3:0]  dp_ca;
    logic        lz_ca;
    logic [6:0]  seg_ca;
    logic        seg_dp_ca;
    logic [3:0]  dig_ca;
    logic        frame_ca;

    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;
    bit   mon_en = 1'b0;
    rec_t q[$];

    logic [15:0]     vec_d   [NV];
    logic [3:0]      vec_dp  [NV];
    logic            vec_lz  [NV];
    logic [3:0][6:0] vec_exp [NV];

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .COMMON_ANODE(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .dp(dp), .lz_blank(lz),
        .seg(seg), .seg_dp(seg_dp), .dig(dig), .frame(frame)
    );

    seven_seg_scanner #(
        .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .COMMON_ANODE(1'b1)
    ) dut_ca (
        .clk(clk), .rst_n(rst_n), .d(d_ca), .dp(dp_ca), .lz_blank(lz_ca),
        .seg(seg_ca), .seg_dp(seg_dp_ca), .dig(dig_ca), .frame(frame_ca)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame) begin
                ok = 1'b1;
                break;
            end
        end
        chk("frame_wait", 32'(ok), 32'd1);
    endtask

    // Expected {frame, dig, seg, seg_dp} at position p of a frame described by r.
    function automatic logic [12:0] exp_cycle(input rec_t r, input int p);
        int         s;
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        logic       e_dp;
        s     = p / 8;
        e_dig = 4'b0000;
        e_seg = 7'h00;
        e_dp  = 1'b0;
        if ((p % 8) >= 2) begin
            e_dig = 4'b0001 << s;
            e_seg = r.seg[s];
            e_dp  = r.dp[s];
        end
        return {(p == 0), e_dig, e_seg, e_dp};
    endfunction

    // Monitor: each frame pulse pops one expected frame and scores all 32 cycles.
    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (mon_en && frame) begin
                if (q.size() == 0) begin
                    chk("scoreboard_underflow", 32'(q.size()), 32'd1);
                end else begin
                    r = q.pop_front();
                    for (int p = 0; p < FLEN; p++) begin
                        if (p > 0) @(negedge clk);
                        chk($sformatf("frame%0d_pos%0d", frames_done, p),
                            32'({frame, dig, seg, seg_dp}), 32'(exp_cycle(r, p)));
                    end
                    frames_done++;
                end
            end
        end
    end

    // Common-anode instance: inverted blank and drive levels after the first release.
    initial begin : ca_checks
        bit seen;
        @(posedge rst_n);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_ca) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ca_frame_seen", 32'(seen), 32'd1);
        chk("ca_blank", 32'({dig_ca, seg_ca, seg_dp_ca}), 32'({4'b1111, 7'h7F, 1'b1}));
        repeat (2) @(negedge clk);
        chk("ca_digit0", 32'({dig_ca, seg_ca, seg_dp_ca}), 32'({4'b1110, 7'h00, 1'b1}));
        repeat (8) @(negedge clk);
        chk("ca_digit1", 32'({dig_ca, seg_ca, seg_dp_ca}), 32'({4'b1101, 7'h40, 1'b1}));
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        int n;
        vec_d[0] = 16'h1234; vec_dp[0] = 4'b0100; vec_lz[0] = 1'b0;
        vec_exp[0] = {7'h06, 7'h5B, 7'h4F, 7'h66};
        vec_d[1] = 16'hABCD; vec_dp[1] = 4'b0000; vec_lz[1] = 1'b0;
        vec_exp[1] = {7'h77, 7'h7C, 7'h39, 7'h5E};
        vec_d[2] = 16'h0050; vec_dp[2] = 4'b1000; vec_lz[2] = 1'b1;
        vec_exp[2] = {7'h00, 7'h00, 7'h6D, 7'h3F};
        vec_d[3] = 16'h0000; vec_dp[3] = 4'b0000; vec_lz[3] = 1'b1;
        vec_exp[3] = {7'h00, 7'h00, 7'h00, 7'h3F};
        vec_d[4] = 16'h0000; vec_dp[4] = 4'b0000; vec_lz[4] = 1'b0;
        vec_exp[4] = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
        for (int x = 0; x < 16; x++) begin
            vec_d[5+x]   = 16'(x);
            vec_dp[5+x]  = 4'(x);
            vec_lz[5+x]  = 1'b0;
            vec_exp[5+x] = {7'h3F, 7'h3F, 7'h3F, seg_tbl[x]};
        end

        rst_n = 1'b0;
        d     = vec_d[0];
        dp    = vec_dp[0];
        lz    = vec_lz[0];
        d_ca  = 16'h0008;
        dp_ca = 4'b0000;
        lz_ca = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({frame, dig, seg, seg_dp}), 32'd0);
        chk("reset_outputs_ca", 32'({frame_ca, dig_ca, seg_ca, seg_dp_ca}),
            32'({1'b0, 4'b1111, 7'h7F, 1'b1}));

        q.push_back('{seg: vec_exp[0], dp: vec_dp[0]});
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Data for frame j+1 is applied in slot 2 of frame j; lz takes effect at frame start.
        for (int j = 0; j < NV; j++) begin
            wait_frame(ok);
            if (!ok) break;
            lz = vec_lz[j];
            if (j + 1 < NV) begin
                repeat (20) @(negedge clk);
                d  = vec_d[j+1];
                dp = vec_dp[j+1];
                q.push_back('{seg: vec_exp[j+1], dp: vec_dp[j+1]});
            end
        end
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        repeat (14) @(negedge clk);
        chk("frames_scored", 32'(frames_done), 32'(NV));
        chk("queue_empty", 32'(q.size()), 32'd0);

        // Asynchronous reset in the middle of a drive window.
        wait_frame(ok);
        repeat (3) @(negedge clk);
        chk("pre_reset_drive", 32'({dig, seg, seg_dp}), 32'({4'b0001, 7'h71, 1'b1}));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({frame, dig, seg, seg_dp}), 32'd0);
        chk("async_reset_ca", 32'({frame_ca, dig_ca, seg_ca, seg_dp_ca}),
            32'({1'b0, 4'b1111, 7'h7F, 1'b1}));
        d  = 16'h1234;
        dp = 4'b0100;
        lz = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_reset", 32'({frame, dig, seg, seg_dp}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("frame_after_release", 32'(frame), 32'd1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) chk("frame_one_cycle", 32'(frame), 32'd0);
            if (i == 2) chk("restart_digit0", 32'({dig, seg, seg_dp}), 32'({4'b0001, 7'h66, 1'b0}));
            if (frame) begin
                n = i;
                break;
            end
        end
        chk("frame_period", 32'(n), 32'd32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
